// File: rtl/ram_pkg.sv
// Shared constants and types for the dual-port data RAM.
package ram_pkg;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   function automatic int nb_of(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/ram_dp_if.sv
// Data-bus port bundle of ram_dp: write port, read port and status.
interface ram_dp_if #(
   parameter int DW = 16,
   parameter int AW = 13
);
   import ram_pkg::*;

   localparam int NB = nb_of(DW);

   logic          we;
   logic [NB-1:0] be;
   logic [AW-1:0] waddr;
   logic [DW-1:0] din;
   logic          re;
   logic [AW-1:0] raddr;
   logic [DW-1:0] dout;
   logic          rvalid;
   logic          busy;
   logic          err;

   modport master (
      output we, be, waddr, din, re, raddr,
      input  dout, rvalid, busy, err
   );

   modport slave (
      input  we, be, waddr, din, re, raddr,
      output dout, rvalid, busy, err
   );

endinterface

// File: rtl/ram_dp_core.sv
// Storage array: byte-enabled write port, synchronous read port, no reset.
module ram_dp_core #(
   parameter int DW = 16,
   parameter int NB = 2,
   parameter int AW = 7
) (
   input  logic          clk,
   input  logic          we,
   input  logic [NB-1:0] be,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] din,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rdata_q, rdata_d;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) mem[waddr][8*i +: 8] <= din[8*i +: 8];
         end
      end
   end

   // Read samples the array before this edge's write lands: old data.
   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[raddr];
   end

   always_ff @(posedge clk) begin
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/ram_dp.sv
// Dual-port data RAM top: clear engine, range check, RDW bypass, output regs.
module ram_dp
   import ram_pkg::*;
#(
   parameter int DW       = 16,
   parameter int AW       = 13,
   parameter int RAM_AW   = 7,
   parameter int RDW_MODE = RDW_OLD,
   parameter int CLEAR_EN = 1
) (
   input  logic     clk,
   input  logic     rst,
   ram_dp_if.slave  bus
);

   localparam int NB = nb_of(DW);

   state_e            state_q, state_d;
   logic [RAM_AW-1:0] ptr_q, ptr_d;
   logic              rvalid_q, rvalid_d;
   logic              err_q, err_d;
   logic              oor_q, oor_d;
   logic [NB-1:0]     byp_be_q, byp_be_d;
   logic [DW-1:0]     byp_data_q, byp_data_d;
   logic [DW-1:0]     hold_q, hold_d;

   logic              busy, w_oor, r_oor, wr_acc, rd_acc;
   logic              c_we;
   logic [NB-1:0]     c_be;
   logic [RAM_AW-1:0] c_waddr;
   logic [DW-1:0]     c_din, c_rdata, dout_c;

   generate
      if (RAM_AW < AW) begin : g_oor
         assign w_oor = |bus.waddr[AW-1:RAM_AW];
         assign r_oor = |bus.raddr[AW-1:RAM_AW];
      end else begin : g_full
         assign w_oor = 1'b0;
         assign r_oor = 1'b0;
      end
   endgenerate

   assign busy   = (state_q == ST_CLEAR);
   assign wr_acc = bus.we && !busy && !w_oor;
   assign rd_acc = bus.re && !busy && !r_oor;

   // Clear engine owns the write port while busy.
   assign c_we    = busy || wr_acc;
   assign c_be    = busy ? '1 : bus.be;
   assign c_waddr = busy ? ptr_q : bus.waddr[RAM_AW-1:0];
   assign c_din   = busy ? '0 : bus.din;

   ram_dp_core #(
      .DW (DW),
      .NB (NB),
      .AW (RAM_AW)
   ) u_core (
      .clk   (clk),
      .we    (c_we),
      .be    (c_be),
      .waddr (c_waddr),
      .din   (c_din),
      .re    (rd_acc),
      .raddr (bus.raddr[RAM_AW-1:0]),
      .rdata (c_rdata)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == ST_CLEAR) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == '1) state_d = ST_RUN;
      end
   end

   always_comb begin
      rvalid_d   = bus.re && !busy;
      oor_d      = r_oor;
      err_d      = !busy && ((bus.we && w_oor) || (bus.re && r_oor));
      byp_data_d = bus.din;
      byp_be_d   = '0;
      if (RDW_MODE == RDW_NEW && wr_acc && rd_acc &&
          bus.waddr[RAM_AW-1:0] == bus.raddr[RAM_AW-1:0])
         byp_be_d = bus.be;

      // dout is the core word merged with bypass lanes, or the held value.
      dout_c = hold_q;
      if (rvalid_q) begin
         if (oor_q) begin
            dout_c = '0;
         end else begin
            for (int unsigned i = 0; i < NB; i++) begin
               dout_c[8*i +: 8] = byp_be_q[i] ? byp_data_q[8*i +: 8] : c_rdata[8*i +: 8];
            end
         end
      end
      hold_d = dout_c;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= (CLEAR_EN != 0) ? ST_CLEAR : ST_RUN;
         ptr_q      <= '0;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
         oor_q      <= 1'b0;
         byp_be_q   <= '0;
         byp_data_q <= '0;
         hold_q     <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         oor_q      <= oor_d;
         byp_be_q   <= byp_be_d;
         byp_data_q <= byp_data_d;
         hold_q     <= hold_d;
      end
   end

   assign bus.dout   = dout_c;
   assign bus.rvalid = rvalid_q;
   assign bus.busy   = busy;
   assign bus.err    = err_q;

endmodule

// File: tb/tb_ram_dp.sv
// Scoreboard bench for ram_dp: one old-data and one bypass instance in lockstep.
module tb_ram_dp;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we = 1'b0, re = 1'b0;
   logic [1:0]  be = '0;
   logic [12:0] waddr = '0, raddr = '0;
   logic [15:0] din = '0;

   int pass_cnt = 0;
   int total_cnt = 0;

   typedef struct {
      logic        busy;
      logic        err;
      logic        rvalid;
      logic        chk;
      logic [15:0] d0;
      logic [15:0] d1;
   } st_t;

   typedef struct {
      logic [15:0] d0;
      logic [15:0] d1;
   } rd_t;

   st_t stq[$];
   rd_t rdq[$];
   st_t st;
   rd_t rd;

   always #5 clk = ~clk;

   ram_dp_if #(.DW(16), .AW(13)) i0 ();
   ram_dp_if #(.DW(16), .AW(13)) i1 ();

   assign i0.we = we;  assign i0.be = be;  assign i0.waddr = waddr;
   assign i0.din = din; assign i0.re = re; assign i0.raddr = raddr;
   assign i1.we = we;  assign i1.be = be;  assign i1.waddr = waddr;
   assign i1.din = din; assign i1.re = re; assign i1.raddr = raddr;

   ram_dp #(.DW(16), .AW(13), .RAM_AW(4), .RDW_MODE(0), .CLEAR_EN(1)) dut0 (
      .clk (clk), .rst (rst), .bus (i0.slave));
   ram_dp #(.DW(16), .AW(13), .RAM_AW(4), .RDW_MODE(1), .CLEAR_EN(1)) dut1 (
      .clk (clk), .rst (rst), .bus (i1.slave));

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else pass_cnt++;
   endtask

   // One cycle of stimulus; expectations describe outputs after the next edge.
   task automatic step(input logic r, input logic w, input logic [1:0] b, input logic [12:0] wa,
                       input logic [15:0] d, input logic rr, input logic [12:0] ra,
                       input logic ebusy, input logic eerr, input logic erv, input logic echk,
                       input logic [15:0] e0, input logic [15:0] e1);
      st_t s;
      rd_t x;
      @(negedge clk);
      rst = r; we = w; be = b; waddr = wa; din = d; re = rr; raddr = ra;
      s.busy = ebusy; s.err = eerr; s.rvalid = erv; s.chk = echk; s.d0 = e0; s.d1 = e1;
      stq.push_back(s);
      if (erv) begin
         x.d0 = e0; x.d1 = e1;
         rdq.push_back(x);
      end
   endtask

   task automatic wr(input logic [12:0] a, input logic [15:0] d, input logic [1:0] b);
      step(1'b1, 1'b1, b, a, d, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic rdx(input logic [12:0] a, input logic [15:0] e0, input logic [15:0] e1);
      step(1'b1, 1'b0, '0, '0, '0, 1'b1, a, 1'b0, 1'b0, 1'b1, 1'b0, e0, e1);
   endtask

   task automatic idle(input logic echk, input logic [15:0] e);
      step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, echk, e, e);
   endtask

   always @(posedge clk) begin
      #2;
      if (stq.size() > 0) begin
         st = stq.pop_front();
         chk("busy0", {15'd0, i0.busy}, {15'd0, st.busy});
         chk("busy1", {15'd0, i1.busy}, {15'd0, st.busy});
         chk("err0", {15'd0, i0.err}, {15'd0, st.err});
         chk("err1", {15'd0, i1.err}, {15'd0, st.err});
         chk("rvalid0", {15'd0, i0.rvalid}, {15'd0, st.rvalid});
         chk("rvalid1", {15'd0, i1.rvalid}, {15'd0, st.rvalid});
         if (st.chk) begin
            chk("dout_hold0", i0.dout, st.d0);
            chk("dout_hold1", i1.dout, st.d1);
         end
         if (i0.rvalid || i1.rvalid) begin
            if (rdq.size() == 0) begin
               chk("unexpected_rvalid", 16'd1, 16'd0);
            end else begin
               rd = rdq.pop_front();
               if (i0.rvalid) chk("rdata0", i0.dout, rd.d0);
               if (i1.rvalid) chk("rdata1", i1.dout, rd.d1);
            end
         end
      end
   end

   initial begin
      // Reset: busy = CLEAR_EN, dout/rvalid/err zero.
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
      for (int k = 1; k <= 16; k++)
         step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, k < 16, 1'b0, 1'b0, 1'b0, '0, '0);
      for (int a = 0; a < 16; a++) rdx(13'(a), 16'h0000, 16'h0000);

      // Byte enables.
      wr(13'd3, 16'hA5C3, 2'b01);
      wr(13'd3, 16'h1200, 2'b10);
      rdx(13'd3, 16'h12C3, 16'h12C3);
      wr(13'd4, 16'hFFFF, 2'b00);
      rdx(13'd4, 16'h0000, 16'h0000);

      // Same-address read during write, full and partial.
      wr(13'd5, 16'h1111, 2'b11);
      step(1'b1, 1'b1, 2'b11, 13'd5, 16'hBEEF, 1'b1, 13'd5, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1111, 16'hBEEF);
      rdx(13'd5, 16'hBEEF, 16'hBEEF);
      wr(13'd6, 16'h2222, 2'b11);
      step(1'b1, 1'b1, 2'b10, 13'd6, 16'h3344, 1'b1, 13'd6, 1'b0, 1'b0, 1'b1, 1'b0, 16'h2222, 16'h3322);
      rdx(13'd6, 16'h3322, 16'h3322);

      // Different-address concurrent access.
      step(1'b1, 1'b1, 2'b11, 13'd7, 16'h7070, 1'b1, 13'd3, 1'b0, 1'b0, 1'b1, 1'b0, 16'h12C3, 16'h12C3);
      rdx(13'd7, 16'h7070, 16'h7070);

      // Out-of-range write and read.
      step(1'b1, 1'b1, 2'b11, 13'h0013, 16'h7777, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      rdx(13'd3, 16'h12C3, 16'h12C3);
      step(1'b1, 1'b0, '0, '0, '0, 1'b1, 13'h0010, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);

      // dout holds with re low.
      wr(13'd9, 16'h4242, 2'b11);
      rdx(13'd9, 16'h4242, 16'h4242);
      for (int k = 0; k < 3; k++) idle(1'b1, 16'h4242);

      // Reset mid-operation, then again mid-clear.
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
      for (int k = 1; k <= 7; k++)
         step(1'b1, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
      for (int k = 1; k <= 16; k++)
         step(1'b1, 1'b1, 2'b11, (k == 8) ? 13'h0100 : 13'(k - 1), 16'hFFFF,
              1'b1, (k == 9) ? 13'h0200 : 13'(k - 1), k < 16, 1'b0, 1'b0, 1'b1, '0, '0);
      for (int a = 0; a < 16; a++) rdx(13'(a), 16'h0000, 16'h0000);
      idle(1'b1, 16'h0000);

      @(posedge clk);
      #3;
      chk("status_queue_drained", 16'(stq.size()), 16'd0);
      chk("read_queue_drained", 16'(rdq.size()), 16'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
